cgra_load_sched: RTL and testbench
==================================

Name: cgra_load_sched

Overview:
- Sequencer that streams a block of configuration/data words from system memory into the CGRA interface.
- Software programs the source address and word count over the register bus, then starts the transfer.
- The block issues pipelined OBI reads on its master port and buffers returned words in a small FIFO.
- It delivers the words to the CGRA over a valid/ready stream, and reports busy/done/error status.

Parameters:
- ADDR_WIDTH, 32, OBI and register address width
- DATA_WIDTH, 32, OBI word and stream width (byte-enable width DATA_WIDTH/8)
- FIFO_DEPTH, 4, receive buffer depth (power of 2, ≥2); also the cap on outstanding reads
- LEN_WIDTH, 16, width of the word-count register

Ports:
- clk_i in 1 clock
- rst_i in 1 asynchronous active-high reset
- reg_valid_i in 1 register access valid
- reg_write_i in 1 1=write, 0=read
- reg_addr_i in ADDR_WIDTH byte address; only bits [4:0] decoded
- reg_wdata_i in DATA_WIDTH write data
- reg_rdata_o out DATA_WIDTH read data
- reg_error_o out 1 unmapped offset
- reg_ready_o out 1 access accepted
- obi_req_o out 1 OBI read request
- obi_addr_o out ADDR_WIDTH word-aligned read address
- obi_we_o out 1 tied 0
- obi_be_o out DATA_WIDTH/8 all ones
- obi_gnt_i in 1 grant
- obi_rvalid_i in 1 read data valid
- obi_rdata_i in DATA_WIDTH read data
- cgra_valid_o out 1 stream word valid
- cgra_data_o out DATA_WIDTH stream word
- cgra_ready_i in 1 CGRA accepts word

Behaviour:
- Reset: all outputs 0, except obi_be_o = all ones and reg_ready_o = 1. FSM in IDLE; FIFO empty; all registers 0.
- Register map, word offsets:
  - 0x00 CTRL, W: bit0 START (write-1 pulse), bit1 ABORT (write-1 pulse); reads 0.
  - 0x04 STATUS, R: bit0 BUSY, bit1 DONE (sticky), bit2 ERR (sticky). Any write clears DONE and ERR.
  - 0x08 SRC_ADDR, RW: bits [1:0] forced 0.
  - 0x0C LEN, RW: LEN_WIDTH bits.
  - 0x10 COUNT, R: words delivered to the CGRA.
- Register-bus timing and errors:
  - reg_ready_o is always 1. reg_rdata_o and reg_error_o are combinational, valid in the same cycle as reg_valid_i.
  - Unmapped offset: reg_error_o=1, write ignored, rdata 0.
  - SRC_ADDR/LEN writes while BUSY are ignored and set ERR.
- FSM states: IDLE, FETCH, DRAIN, FLUSH.
  - IDLE→FETCH on START with LEN≠0. Captures the working address/remaining count, clears COUNT/DONE/ERR.
  - START with LEN=0: DONE=1 next cycle, no OBI traffic, stay in IDLE.
  - START while BUSY: ignored, ERR=1.
  - FETCH: obi_req_o=1 while remaining>0 and (outstanding + FIFO occupancy) < FIFO_DEPTH.
    - obi_addr_o and obi_req_o stay stable until obi_gnt_i.
    - On each gnt: addr += 4 (wraps modulo 2^ADDR_WIDTH), remaining−1, outstanding+1.
    - When remaining reaches 0 → DRAIN.
  - DRAIN: wait until outstanding=0 and FIFO empty, then → IDLE with DONE=1.
  - ABORT in FETCH/DRAIN → FLUSH.
    - Drop obi_req_o only if not currently waiting on gnt; an un-granted request is held until gnt and counted as outstanding.
    - In FLUSH, returning rvalid data is discarded and the FIFO is emptied immediately (cgra_valid_o=0).
    - When outstanding=0 → IDLE with ERR=1, DONE=0. ABORT in IDLE is ignored.
- rvalid handling: each rvalid pushes obi_rdata_i into the FIFO (not in FLUSH), outstanding−1.
  - The credit rule guarantees no overflow. An rvalid with outstanding=0 is ignored and sets ERR.
- Stream: cgra_valid_o = FIFO non-empty; cgra_data_o = FIFO head, stable while valid && !ready.
  - Pop and COUNT+1 on valid && ready.
  - Push and pop in the same cycle are both performed; occupancy unchanged.
- Latency: START accepted at edge N → obi_req_o=1 in cycle N+1. First word reaches cgra_valid_o the cycle after its rvalid.
- BUSY = state≠IDLE.
- Reset mid-transfer: immediate return to the reset state. Outstanding OBI responses after reset release are ignored; no ERR is set.

Optional Feature:
- Macro CGRA_LOAD_SCHED_IRQ_EN.
- Defined:
  - Adds output irq_o (1 bit) and CTRL bit2 IRQ_EN (RW, reset 0; CTRL reads back bit2).
  - irq_o = IRQ_EN & (DONE | ERR), registered; cleared by writing STATUS.
- Undefined: no irq_o port; CTRL bit2 is ignored and reads 0.

Decomposition:
- Package cgra_load_sched_pkg:
  - register offset localparams (CTRL/STATUS/SRC_ADDR/LEN/COUNT)
  - STATUS/CTRL bit index constants
  - FSM state enum typedef
- One sub-module, cgra_load_sched_fifo: parameterised DATA_WIDTH/DEPTH synchronous FIFO with push/pop/flush, empty, and occupancy count.

Test Plan:
- SRC=0x1000, LEN=3, gnt tied 1, rvalid 1 cycle after gnt, ready=1 → reads at 0x1000/0x1004/0x1008; 3 words streamed in order; COUNT=3; DONE=1; BUSY=0.
- LEN=10, FIFO_DEPTH=4, cgra_ready_i=0 → exactly 4 reads granted, obi_req_o then held 0. Raise ready → remaining 6 fetched; COUNT=10.
- gnt delayed 3 cycles → obi_addr_o/obi_req_o stable throughout; no address skipped.
- ABORT after 2 of 8 grants with 2 outstanding → both rvalids discarded, cgra_valid_o=0, IDLE with ERR=1, DONE=0, COUNT≤2.
- LEN=0 START → DONE=1 one cycle later, obi_req_o never asserted. START while BUSY → ERR=1, transfer unaffected. Read offset 0x14 → reg_error_o=1.
- rst_i asserted mid-FETCH → all outputs at reset values that same cycle; STATUS=0 after release.

Source files
------------

// File: rtl/cgra_load_sched_pkg.sv
// Shared register offsets, CTRL/STATUS bit positions and sequencer states for cgra_load_sched.
package cgra_load_sched_pkg;

    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_STATUS = 5'h04;
    localparam logic [4:0] OFF_SRC    = 5'h08;
    localparam logic [4:0] OFF_LEN    = 5'h0C;
    localparam logic [4:0] OFF_COUNT  = 5'h10;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_FLUSH
    } state_e;

endpackage

// File: rtl/cgra_load_sched_fifo.sv
// Small synchronous FIFO with flush; storage is left unreset, only the pointers/count are reset.
module cgra_load_sched_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [DATA_WIDTH-1:0]      wdata_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [DATA_WIDTH-1:0]      rdata_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wptr, rptr;
    logic [AW:0]           cnt;
    logic                  do_push, do_pop;

    assign do_pop  = pop_i && (cnt != '0);
    assign do_push = push_i && ((cnt != (AW+1)'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush_i) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem[wptr] <= wdata_i;
    end

    assign rdata_o = mem[rptr];
    assign empty_o = (cnt == '0);
    assign count_o = cnt;

endmodule

// File: rtl/cgra_load_sched.sv
// Register-programmed OBI read sequencer feeding the CGRA stream through a credit-limited FIFO.
// Optional interrupt output and CTRL.IRQ_EN enabled by defining CGRA_LOAD_SCHED_IRQ_EN.
module cgra_load_sched
    import cgra_load_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    reg_valid_i,
    input  logic                    reg_write_i,
    input  logic [ADDR_WIDTH-1:0]   reg_addr_i,
    input  logic [DATA_WIDTH-1:0]   reg_wdata_i,
    output logic [DATA_WIDTH-1:0]   reg_rdata_o,
    output logic                    reg_error_o,
    output logic                    reg_ready_o,
    output logic                    obi_req_o,
    output logic [ADDR_WIDTH-1:0]   obi_addr_o,
    output logic                    obi_we_o,
    output logic [DATA_WIDTH/8-1:0] obi_be_o,
    input  logic                    obi_gnt_i,
    input  logic                    obi_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
    output logic                    cgra_valid_o,
    output logic [DATA_WIDTH-1:0]   cgra_data_o,
    input  logic                    cgra_ready_i
`ifdef CGRA_LOAD_SCHED_IRQ_EN
    ,
    output logic                    irq_o
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e                state;
    logic [ADDR_WIDTH-1:0] src_addr, addr;
    logic [LEN_WIDTH-1:0]  len, remaining, count;
    logic [CW-1:0]         outstanding, fifo_cnt;
    logic                  done, err, hold_req;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_empty, fifo_push, fifo_pop, fifo_flush;
    logic [4:0]            offset;
    logic                  wr, wr_ctrl, start, abort, abort_go, busy;
    logic                  fire, rsp_ok, stray, credit_ok, req;
    logic [CW:0]           inflight;
    logic                  unused_addr;
`ifdef CGRA_LOAD_SCHED_IRQ_EN
    logic                  irq_en;
`endif

    assign offset      = reg_addr_i[4:0];
    assign unused_addr = ^reg_addr_i[ADDR_WIDTH-1:5];
    assign wr          = reg_valid_i && reg_write_i;
    assign wr_ctrl     = wr && (offset == OFF_CTRL);
    assign start       = wr_ctrl && reg_wdata_i[CTRL_START];
    assign abort       = wr_ctrl && reg_wdata_i[CTRL_ABORT];
    assign busy        = (state != S_IDLE);
    assign abort_go    = abort && ((state == S_FETCH) || (state == S_DRAIN));

    // Outstanding reads plus buffered words never exceed the FIFO depth.
    assign inflight  = {1'b0, outstanding} + {1'b0, fifo_cnt};
    assign credit_ok = inflight < (CW+1)'(FIFO_DEPTH);

    always_comb begin
        req = 1'b0;
        case (state)
            S_FETCH: req = (remaining != '0) && credit_ok;
            S_FLUSH: req = hold_req;
            default: req = 1'b0;
        endcase
    end

    assign fire   = req && obi_gnt_i;
    assign rsp_ok = obi_rvalid_i && (outstanding != '0);
    assign stray  = obi_rvalid_i && (outstanding == '0) && busy;

    assign fifo_flush   = (state == S_FLUSH) || abort_go;
    assign fifo_push    = rsp_ok && (state != S_FLUSH);
    assign cgra_valid_o = !fifo_empty && (state != S_FLUSH);
    assign fifo_pop     = cgra_valid_o && cgra_ready_i;
    assign cgra_data_o  = cgra_valid_o ? fifo_head : '0;

    assign obi_req_o   = req;
    assign obi_addr_o  = addr;
    assign obi_we_o    = 1'b0;
    assign obi_be_o    = '1;
    assign reg_ready_o = 1'b1;

    cgra_load_sched_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .wdata_i (obi_rdata_i),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .rdata_o (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            src_addr    <= '0;
            len         <= '0;
            addr        <= '0;
            remaining   <= '0;
            count       <= '0;
            outstanding <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            hold_req    <= 1'b0;
        end else begin
            case ({fire, rsp_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (fifo_pop) count <= count + 1'b1;
            if (fire) begin
                addr      <= addr + ADDR_WIDTH'(4);
                remaining <= remaining - 1'b1;
                hold_req  <= 1'b0;
            end

            if (wr && (offset == OFF_STATUS)) begin
                done <= 1'b0;
                err  <= 1'b0;
            end
            if (wr && (offset == OFF_SRC)) begin
                if (busy) err <= 1'b1;
                else      src_addr <= {reg_wdata_i[ADDR_WIDTH-1:2], 2'b00};
            end
            if (wr && (offset == OFF_LEN)) begin
                if (busy) err <= 1'b1;
                else      len <= reg_wdata_i[LEN_WIDTH-1:0];
            end
            if (stray || (start && busy)) err <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        done <= (len == '0);
                        err  <= 1'b0;
                        if (len != '0) begin
                            state     <= S_FETCH;
                            addr      <= src_addr;
                            remaining <= len;
                            count     <= '0;
                        end
                    end
                end
                S_FETCH: begin
                    if (abort) begin
                        state    <= S_FLUSH;
                        hold_req <= req && !obi_gnt_i;
                    end else if (fire && (remaining == LEN_WIDTH'(1))) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        state    <= S_FLUSH;
                        hold_req <= 1'b0;
                    end else if ((outstanding == '0) && fifo_empty) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    if ((outstanding == '0) && !hold_req) begin
                        state <= S_IDLE;
                        err   <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CGRA_LOAD_SCHED_IRQ_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_en <= 1'b0;
            irq_o  <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en <= reg_wdata_i[CTRL_IRQ_EN];
            if (wr && (offset == OFF_STATUS)) irq_o <= 1'b0;
            else                               irq_o <= irq_en && (done || err);
        end
    end
`endif

    always_comb begin
        reg_rdata_o = '0;
        reg_error_o = 1'b0;
        if (reg_valid_i) begin
            case (offset)
                OFF_CTRL: begin
`ifdef CGRA_LOAD_SCHED_IRQ_EN
                    reg_rdata_o[CTRL_IRQ_EN] = irq_en;
`endif
                end
                OFF_STATUS: begin
                    reg_rdata_o[ST_BUSY] = busy;
                    reg_rdata_o[ST_DONE] = done;
                    reg_rdata_o[ST_ERR]  = err;
                end
                OFF_SRC:   reg_rdata_o[ADDR_WIDTH-1:0] = src_addr;
                OFF_LEN:   reg_rdata_o[LEN_WIDTH-1:0]  = len;
                OFF_COUNT: reg_rdata_o[LEN_WIDTH-1:0]  = count;
                default:   reg_error_o = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_cgra_load_sched.sv
// Directed bench for cgra_load_sched: OBI memory responder, stream monitor and a linear test sequence.
module tb_cgra_load_sched;
    import cgra_load_sched_pkg::*;

    logic        clk_i, rst_i;
    logic        reg_valid_i, reg_write_i;
    logic [31:0] reg_addr_i, reg_wdata_i, reg_rdata_o;
    logic        reg_error_o, reg_ready_o;
    logic        obi_req_o, obi_we_o, obi_gnt_i, obi_rvalid_i;
    logic [31:0] obi_addr_o, obi_rdata_i;
    logic [3:0]  obi_be_o;
    logic        cgra_valid_o, cgra_ready_i;
    logic [31:0] cgra_data_o;

    cgra_load_sched #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .FIFO_DEPTH (4),
        .LEN_WIDTH  (16)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .reg_valid_i  (reg_valid_i),
        .reg_write_i  (reg_write_i),
        .reg_addr_i   (reg_addr_i),
        .reg_wdata_i  (reg_wdata_i),
        .reg_rdata_o  (reg_rdata_o),
        .reg_error_o  (reg_error_o),
        .reg_ready_o  (reg_ready_o),
        .obi_req_o    (obi_req_o),
        .obi_addr_o   (obi_addr_o),
        .obi_we_o     (obi_we_o),
        .obi_be_o     (obi_be_o),
        .obi_gnt_i    (obi_gnt_i),
        .obi_rvalid_i (obi_rvalid_i),
        .obi_rdata_i  (obi_rdata_i),
        .cgra_valid_o (cgra_valid_o),
        .cgra_data_o  (cgra_data_o),
        .cgra_ready_i (cgra_ready_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // Memory responder: programmable grant delay/limit, one-cycle read latency unless held.
    int          gnt_delay  = 0;
    int          gnt_limit  = 1000000;
    int          grants     = 0;
    int          req_cycles = 0;
    int          wcnt       = 0;
    bit          rv_hold    = 0;
    logic [31:0] rq[$];
    logic [31:0] exp_addr   = '0;
    logic        prev_wait  = 1'b0;
    logic [31:0] prev_addr  = '0;

    initial begin
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b0;
        obi_rdata_i  = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (!rv_hold && rq.size() > 0) begin
                obi_rvalid_i = 1'b1;
                obi_rdata_i  = rq.pop_front();
            end else begin
                obi_rvalid_i = 1'b0;
                obi_rdata_i  = '0;
            end
            #1;
            obi_gnt_i = obi_req_o && (wcnt >= gnt_delay) && (grants < gnt_limit);
            @(negedge clk_i);
            if (prev_wait) begin
                chk("req_held", 32'(obi_req_o), 32'd1);
                chk("addr_held", obi_addr_o, prev_addr);
            end
            if (obi_req_o) req_cycles++;
            if (obi_req_o && obi_gnt_i) begin
                chk("rd_addr", obi_addr_o, exp_addr);
                exp_addr = exp_addr + 32'd4;
                rq.push_back(mk(obi_addr_o));
                grants++;
                wcnt = 0;
            end else if (obi_req_o) begin
                wcnt++;
            end
            prev_wait = obi_req_o && !obi_gnt_i;
            prev_addr = obi_addr_o;
        end
    end

    // Stream monitor: in-order data and hold-while-stalled.
    int          delivered = 0;
    logic [31:0] exp_daddr = '0;
    logic        pv        = 1'b0;
    logic [31:0] pd        = '0;

    initial begin
        forever begin
            @(negedge clk_i);
            if (pv) chk("data_stable", cgra_data_o, pd);
            if (cgra_valid_o && cgra_ready_i) begin
                chk("stream_data", cgra_data_o, mk(exp_daddr));
                exp_daddr = exp_daddr + 32'd4;
                delivered++;
            end
            pv = cgra_valid_o && !cgra_ready_i && !rst_i;
            pd = cgra_data_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] rdv;
    logic        rde;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic reg_wr(input logic [4:0] off, input logic [31:0] d);
        reg_valid_i = 1'b1;
        reg_write_i = 1'b1;
        reg_addr_i  = {27'b0, off};
        reg_wdata_i = d;
        cyc(1);
        reg_valid_i = 1'b0;
        reg_write_i = 1'b0;
    endtask

    task automatic reg_rd(input logic [4:0] off);
        reg_valid_i = 1'b1;
        reg_write_i = 1'b0;
        reg_addr_i  = {27'b0, off};
        #3;
        rdv = reg_rdata_o;
        rde = reg_error_o;
        cyc(1);
        reg_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        int i;
        for (i = 0; i < maxc; i++) begin
            reg_rd(OFF_STATUS);
            if (!rdv[ST_BUSY]) break;
        end
        chk(tag, 32'(i < maxc), 32'd1);
    endtask

    task automatic setup(input logic [31:0] src, input logic [31:0] n);
        reg_wr(OFF_SRC, src);
        reg_wr(OFF_LEN, n);
        exp_addr   = src;
        exp_daddr  = src;
        grants     = 0;
        delivered  = 0;
        req_cycles = 0;
    endtask

    initial begin
        rst_i        = 1'b1;
        reg_valid_i  = 1'b0;
        reg_write_i  = 1'b0;
        reg_addr_i   = '0;
        reg_wdata_i  = '0;
        cgra_ready_i = 1'b0;
        cyc(2);

        chk("rst_req", 32'(obi_req_o), 32'd0);
        chk("rst_addr", obi_addr_o, 32'd0);
        chk("rst_we", 32'(obi_we_o), 32'd0);
        chk("rst_be", 32'(obi_be_o), 32'hF);
        chk("rst_ready", 32'(reg_ready_o), 32'd1);
        chk("rst_cvalid", 32'(cgra_valid_o), 32'd0);
        chk("rst_cdata", cgra_data_o, 32'd0);
        rst_i = 1'b0;
        cyc(1);
        reg_rd(OFF_STATUS); chk("rst_status", rdv, 32'd0);
        reg_rd(OFF_COUNT);  chk("rst_count", rdv, 32'd0);
        reg_rd(OFF_LEN);    chk("rst_len", rdv, 32'd0);

        // Basic 3-word transfer
        setup(32'h1003, 32'd3);
        exp_addr  = 32'h1000;
        exp_daddr = 32'h1000;
        reg_rd(OFF_SRC); chk("src_align", rdv, 32'h1000);
        cgra_ready_i = 1'b1;
        reg_wr(OFF_CTRL, 32'h1);
        chk("t1_req_lat", 32'(obi_req_o), 32'd1);
        chk("t1_addr0", obi_addr_o, 32'h1000);
        cyc(1);
        chk("t1_valid_early", 32'(cgra_valid_o), 32'd0);
        cyc(1);
        chk("t1_valid_lat", 32'(cgra_valid_o), 32'd1);
        chk("t1_data0", cgra_data_o, mk(32'h1000));
        wait_idle(50, "t1_timeout");
        chk("t1_grants", 32'(grants), 32'd3);
        chk("t1_delivered", 32'(delivered), 32'd3);
        reg_rd(OFF_COUNT);  chk("t1_count", rdv, 32'd3);
        reg_rd(OFF_STATUS); chk("t1_status", rdv, 32'h2);

        // Credit limit with a stalled consumer
        cgra_ready_i = 1'b0;
        setup(32'h2000, 32'd10);
        reg_wr(OFF_CTRL, 32'h1);
        cyc(20);
        chk("t2_grants_cap", 32'(grants), 32'd4);
        chk("t2_req_off", 32'(obi_req_o), 32'd0);
        chk("t2_valid", 32'(cgra_valid_o), 32'd1);
        chk("t2_head", cgra_data_o, mk(32'h2000));
        reg_rd(OFF_STATUS); chk("t2_busy", rdv, 32'h1);
        cgra_ready_i = 1'b1;
        wait_idle(80, "t2_timeout");
        chk("t2_grants", 32'(grants), 32'd10);
        chk("t2_delivered", 32'(delivered), 32'd10);
        reg_rd(OFF_COUNT);  chk("t2_count", rdv, 32'd10);
        reg_rd(OFF_STATUS); chk("t2_status", rdv, 32'h2);

        // Slow grant: request must hold steady for three wait cycles per read
        gnt_delay = 3;
        setup(32'h3000, 32'd3);
        reg_wr(OFF_CTRL, 32'h1);
        wait_idle(80, "t3_timeout");
        chk("t3_grants", 32'(grants), 32'd3);
        chk("t3_req_cycles", 32'(req_cycles), 32'd12);
        chk("t3_delivered", 32'(delivered), 32'd3);
        reg_rd(OFF_COUNT); chk("t3_count", rdv, 32'd3);
        gnt_delay = 0;

        // Abort with two reads outstanding and a third request waiting on grant
        cgra_ready_i = 1'b0;
        rv_hold      = 1'b1;
        gnt_limit    = 2;
        setup(32'h4000, 32'd8);
        reg_wr(OFF_CTRL, 32'h1);
        cyc(6);
        chk("t4_grants2", 32'(grants), 32'd2);
        chk("t4_req_wait", 32'(obi_req_o), 32'd1);
        chk("t4_addr_wait", obi_addr_o, 32'h4008);
        reg_wr(OFF_CTRL, 32'h2);
        chk("t4_req_hold", 32'(obi_req_o), 32'd1);
        chk("t4_addr_hold", obi_addr_o, 32'h4008);
        chk("t4_valid_abort", 32'(cgra_valid_o), 32'd0);
        reg_rd(OFF_STATUS); chk("t4_busy", rdv, 32'h1);
        gnt_limit = 3;
        cyc(2);
        chk("t4_grants3", 32'(grants), 32'd3);
        chk("t4_req_drop", 32'(obi_req_o), 32'd0);
        cgra_ready_i = 1'b1;
        rv_hold      = 1'b0;
        cyc(2);
        chk("t4_valid_flush", 32'(cgra_valid_o), 32'd0);
        wait_idle(30, "t4_timeout");
        reg_rd(OFF_STATUS); chk("t4_status", rdv, 32'h4);
        reg_rd(OFF_COUNT);  chk("t4_count", rdv, 32'd0);
        chk("t4_delivered", 32'(delivered), 32'd0);
        gnt_limit = 1000000;

        // Zero-length start
        reg_wr(OFF_STATUS, 32'h0);
        reg_rd(OFF_STATUS); chk("t5_cleared", rdv, 32'h0);
        setup(32'h4400, 32'd0);
        reg_wr(OFF_CTRL, 32'h1);
        reg_rd(OFF_STATUS); chk("t5_done", rdv, 32'h2);
        cyc(3);
        chk("t5_no_req", 32'(req_cycles), 32'd0);

        // Start and LEN writes while busy are rejected
        setup(32'h5000, 32'd4);
        reg_wr(OFF_CTRL, 32'h1);
        reg_wr(OFF_CTRL, 32'h1);
        reg_wr(OFF_LEN, 32'd7);
        wait_idle(50, "t5_timeout");
        reg_rd(OFF_STATUS); chk("t5_status", rdv, 32'h6);
        reg_rd(OFF_COUNT);  chk("t5_count", rdv, 32'd4);
        reg_rd(OFF_LEN);    chk("t5_len", rdv, 32'd4);
        chk("t5_grants", 32'(grants), 32'd4);

        // Register decode
        reg_rd(5'h14);    chk("map_err", 32'(rde), 32'd1); chk("map_rdata", rdv, 32'd0);
        reg_rd(OFF_CTRL); chk("ctrl_rd", rdv, 32'd0);      chk("ctrl_err", 32'(rde), 32'd0);
        reg_rd(OFF_SRC);  chk("src_rd", rdv, 32'h5000);

        // Asynchronous reset in the middle of a fetch
        cgra_ready_i = 1'b0;
        rv_hold      = 1'b1;
        setup(32'h6000, 32'd8);
        reg_wr(OFF_CTRL, 32'h1);
        cyc(3);
        chk("t6_req_pre", 32'(obi_req_o), 32'd1);
        rst_i = 1'b1;
        #1;
        chk("t6_req_rst", 32'(obi_req_o), 32'd0);
        chk("t6_addr_rst", obi_addr_o, 32'd0);
        chk("t6_be_rst", 32'(obi_be_o), 32'hF);
        chk("t6_ready_rst", 32'(reg_ready_o), 32'd1);
        chk("t6_valid_rst", 32'(cgra_valid_o), 32'd0);
        cyc(1);
        rst_i   = 1'b0;
        rv_hold = 1'b0;
        cyc(6);
        reg_rd(OFF_STATUS); chk("t6_status", rdv, 32'h0);
        reg_rd(OFF_COUNT);  chk("t6_count", rdv, 32'd0);
        chk("t6_valid", 32'(cgra_valid_o), 32'd0);
        chk("t6_req", 32'(obi_req_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
